// File: rtl/link_master_sequencer.sv
// link_master_sequencer: master end of the linked-machine control link.
//   Starts one linked slave state machine, follows its STATE_OUT step by
//   step and reports completion, ack timeout, watchdog expiry or bad steps.
//   Optional build macro LINK_MASTER_SYNC_EN: when defined, START and ABORT
//   each pass through a 2-flop synchroniser before edge detection.
// Ports:
//   CLK            in  1  system clock, rising edge
//   RESET          in  1  synchronous active-high reset
//   START          in  1  run request (rising edge significant)
//   ABORT          in  1  cancel request (rising edge significant)
//   SLAVE_STATE    in  4  slave STATE_OUT
//   MASTER_CONTROL out 2  2'b11 start command, 2'b00 idle
//   SLAVE_RESET    out 1  one-cycle synchronous reset to the slave
//   MASTER_STATE   out 3  current FSM state code
//   BUSY           out 1  high in ARM, CHECK, START, RUN
//   DONE           out 1  high in DONE
//   ERROR          out 1  high in ERROR
//   ERR_CODE       out 2  1 ack timeout, 2 watchdog, 3 illegal step
module link_master_sequencer #(
    parameter logic [3:0] TERMINAL_STATE  = 4'd8,
    parameter int         ACK_TIMEOUT     = 16,
    parameter int         WATCHDOG_CYCLES = 60000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       ABORT,
    input  logic [3:0] SLAVE_STATE,
    output logic [1:0] MASTER_CONTROL,
    output logic       SLAVE_RESET,
    output logic [2:0] MASTER_STATE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR,
    output logic [1:0] ERR_CODE
);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_CHECK = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [3:0]        last_q, last_d;
    logic [1:0]        err_q, err_d;
    logic [1:0]        mc_q;
    logic              srst_q, srst_d;
    logic              busy_q, done_q, error_q;
    logic              start_s, abort_s, start_q, abort_q;
    logic              start_edge, abort_edge;
    logic              tmo_hit, wd_hit;

`ifdef LINK_MASTER_SYNC_EN
    logic [1:0] start_sync_q, abort_sync_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            start_sync_q <= 2'b00;
            abort_sync_q <= 2'b00;
        end else begin
            start_sync_q <= {start_sync_q[0], START};
            abort_sync_q <= {abort_sync_q[0], ABORT};
        end
    end

    assign start_s = start_sync_q[1];
    assign abort_s = abort_sync_q[1];
`else
    assign start_s = START;
    assign abort_s = ABORT;
`endif

    assign start_edge = start_s & ~start_q;
    assign abort_edge = abort_s & ~abort_q;
    assign tmo_hit    = tmo_q == TMO_W'(ACK_TIMEOUT - 1);
    assign wd_hit     = wd_q == WD_W'(WATCHDOG_CYCLES - 1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            wd_q    <= '0;
            last_q  <= 4'd0;
            err_q   <= 2'd0;
            mc_q    <= 2'b00;
            srst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            wd_q    <= wd_d;
            last_q  <= last_d;
            err_q   <= err_d;
            mc_q    <= (state_d == S_START) ? 2'b11 : 2'b00;
            srst_q  <= srst_d;
            busy_q  <= state_d inside {S_ARM, S_CHECK, S_START, S_RUN};
            done_q  <= state_d == S_DONE;
            error_q <= state_d == S_ERROR;
            start_q <= start_s;
            abort_q <= abort_s;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        wd_d    = wd_q;
        last_d  = last_q;
        err_d   = err_q;
        srst_d  = 1'b0;
        // Abort beats every other transition, including a coincident start.
        if (abort_edge && state_q != S_IDLE) begin
            state_d = S_IDLE;
            srst_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (start_edge && !abort_edge) state_d = S_ARM;
                S_ARM: begin
                    state_d = S_CHECK;
                    tmo_d   = '0;
                end
                S_CHECK: begin
                    if (SLAVE_STATE == 4'd0) begin
                        state_d = S_START;
                        tmo_d   = '0;
                    end else if (tmo_hit) begin
                        state_d = S_ERROR;
                        err_d   = 2'd1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_START: begin
                    if (SLAVE_STATE == 4'd1) begin
                        state_d = S_RUN;
                        last_d  = 4'd1;
                        wd_d    = '0;
                    end else if (tmo_hit) begin
                        state_d = S_ERROR;
                        err_d   = 2'd1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                S_RUN: begin
                    // Step checks are evaluated before the watchdog.
                    if (SLAVE_STATE == last_q + 4'd1) begin
                        last_d = SLAVE_STATE;
                        wd_d   = '0;
                        if (SLAVE_STATE == TERMINAL_STATE) state_d = S_DONE;
                    end else if (SLAVE_STATE == last_q) begin
                        if (wd_hit) begin
                            state_d = S_ERROR;
                            err_d   = 2'd2;
                        end else begin
                            wd_d = wd_q + 1'b1;
                        end
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 2'd3;
                    end
                end
                S_DONE, S_ERROR: if (start_edge) state_d = S_ARM;
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d == S_ARM) begin
            err_d  = 2'd0;
            srst_d = 1'b1;
        end
    end

    assign MASTER_CONTROL = mc_q;
    assign SLAVE_RESET    = srst_q;
    assign MASTER_STATE   = state_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign ERROR          = error_q;
    assign ERR_CODE       = err_q;
endmodule

// File: tb/tb_link_master_sequencer.sv
// tb_link_master_sequencer: directed scoreboard bench for link_master_sequencer.
module tb_link_master_sequencer;
    localparam int ACK = 4;
    localparam int WDC = 10;
`ifdef LINK_MASTER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [3:0] SLAVE_STATE;
    logic [1:0] MASTER_CONTROL;
    logic       SLAVE_RESET;
    logic [2:0] MASTER_STATE;
    logic       BUSY, DONE, ERROR;
    logic [1:0] ERR_CODE;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] exp_q[$];
    logic [2:0] prev_st = 3'd0;

    logic       dead = 1'b0, stall = 1'b0, illegal = 1'b0;
    logic [3:0] sst = 4'd0;
    logic [1:0] cnt = 2'd0;

    always #5 CLK = ~CLK;

    link_master_sequencer #(
        .TERMINAL_STATE (4'd8),
        .ACK_TIMEOUT    (ACK),
        .WATCHDOG_CYCLES(WDC)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .START         (START),
        .ABORT         (ABORT),
        .SLAVE_STATE   (SLAVE_STATE),
        .MASTER_CONTROL(MASTER_CONTROL),
        .SLAVE_RESET   (SLAVE_RESET),
        .MASTER_STATE  (MASTER_STATE),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERROR         (ERROR),
        .ERR_CODE      (ERR_CODE)
    );

    assign SLAVE_STATE = sst;

    // Behavioural slave: 1 on the edge that samples the start command, then 4 cycles per state up to 8.
    always @(posedge CLK) begin
        if (RESET || SLAVE_RESET) begin
            sst <= 4'd0;
            cnt <= 2'd0;
        end else if (sst == 4'd0) begin
            if (MASTER_CONTROL == 2'b11 && !dead) begin
                sst <= 4'd1;
                cnt <= 2'd0;
            end
        end else if (sst != 4'd8 && !(stall && sst == 4'd3)) begin
            if (cnt == 2'd3) begin
                sst <= (illegal && sst == 4'd2) ? 4'd5 : sst + 4'd1;
                cnt <= 2'd0;
            end else begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every state change must match the next expected state queued by the stimulus.
    always @(negedge CLK) begin
        if (!$isunknown(MASTER_STATE) && MASTER_STATE !== prev_st) begin
            logic [2:0] e;
            e = exp_q.size() != 0 ? exp_q.pop_front() : 3'd7;
            chk("transition", MASTER_STATE, e);
            chk("flags", {BUSY, DONE, ERROR},
                {MASTER_STATE >= 3'd1 && MASTER_STATE <= 3'd4, MASTER_STATE == 3'd5, MASTER_STATE == 3'd6});
            prev_st = MASTER_STATE;
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic push(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic [2:0] d, input logic [2:0] e);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (MASTER_STATE !== s && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", MASTER_STATE, s);
    endtask

    task automatic wait_slave(input logic [3:0] v, input int budget);
        int n = 0;
        while (SLAVE_STATE !== v && n < budget) begin
            tick();
            n++;
        end
        chk("wait_slave", SLAVE_STATE, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) tick();
        RESET = 1'b0;
        chk("rst_state", MASTER_STATE, 0);
        chk("rst_mc", MASTER_CONTROL, 0);
        chk("rst_srst", SLAVE_RESET, 0);
        chk("rst_flags", {BUSY, DONE, ERROR}, 0);
        chk("rst_err", ERR_CODE, 0);

        // Normal run with latency and handshake checks.
        push(1, 2, 3, 4, 5);
        START = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (MASTER_STATE !== 3'd1 && n < 10);
        START = 1'b0;
        chk("start_latency", n, LAT);
        chk("arm_srst", SLAVE_RESET, 1);
        tick();
        chk("check_state", MASTER_STATE, 2);
        chk("check_srst", SLAVE_RESET, 0);
        tick();
        chk("start_state", MASTER_STATE, 3);
        chk("start_mc", MASTER_CONTROL, 2'b11);
        n = 0;
        while (MASTER_STATE === 3'd3 && n < 20) begin
            n++;
            tick();
        end
        chk("start_len", n, 2);
        chk("run_state", MASTER_STATE, 4);
        chk("run_mc", MASTER_CONTROL, 0);
        chk("run_busy", BUSY, 1);
        wait_slave(4'd8, 100);
        chk("pre_done", MASTER_STATE, 4);
        tick();
        chk("done_state", MASTER_STATE, 5);
        chk("done_flags", {BUSY, DONE, ERROR}, 3'b010);

        // Re-run from DONE.
        push(1, 2, 3, 4, 5);
        pulse_start();
        wait_state(3'd1, 10);
        wait_state(3'd5, 100);
        chk("rerun_done", DONE, 1);

        // Dead slave: START times out.
        dead = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(6);
        pulse_start();
        wait_state(3'd3, 10);
        n = 0;
        while (MASTER_STATE === 3'd3 && n < 20) begin
            n++;
            tick();
        end
        chk("ack_timeout_len", n, ACK);
        chk("dead_error", ERROR, 1);
        chk("dead_code", ERR_CODE, 1);
        chk("dead_mc", MASTER_CONTROL, 0);
        chk("dead_busy", BUSY, 0);
        dead = 1'b0;

        // Stalled slave at state 3: watchdog.
        stall = 1'b1;
        push(1, 2, 3, 4, 6);
        pulse_start();
        wait_state(3'd1, 10);
        chk("arm_err_clear", ERR_CODE, 0);
        wait_slave(4'd3, 100);
        n = 0;
        while (MASTER_STATE === 3'd4 && n < 50) begin
            n++;
            tick();
        end
        chk("wd_len", n, WDC + 1);
        chk("wd_error", ERROR, 1);
        chk("wd_code", ERR_CODE, 2);
        stall = 1'b0;

        // Illegal step 2 -> 5.
        illegal = 1'b1;
        push(1, 2, 3, 4, 6);
        pulse_start();
        wait_slave(4'd5, 100);
        chk("pre_illegal", MASTER_STATE, 4);
        tick();
        chk("illegal_state", MASTER_STATE, 6);
        chk("illegal_code", ERR_CODE, 3);
        illegal = 1'b0;

        // Abort during RUN at slave state 4.
        push(1, 2, 3, 4, 0);
        pulse_start();
        wait_slave(4'd4, 100);
        chk("abort_in_run", MASTER_STATE, 4);
        ABORT = 1'b1;
        wait_state(3'd0, 10);
        chk("abort_srst", SLAVE_RESET, 1);
        chk("abort_busy", BUSY, 0);
        tick();
        chk("abort_srst_end", SLAVE_RESET, 0);
        ABORT = 1'b0;
        repeat (2) tick();

        // Start and abort rising together in IDLE: dropped.
        START = 1'b1;
        ABORT = 1'b1;
        repeat (8) tick();
        chk("both_idle", MASTER_STATE, 0);
        chk("both_srst", SLAVE_RESET, 0);
        START = 1'b0;
        ABORT = 1'b0;
        repeat (2) tick();

        // Mid-run reset.
        push(1, 2, 3, 4, 0);
        pulse_start();
        wait_state(3'd4, 20);
        repeat (3) tick();
        RESET = 1'b1;
        tick();
        chk("mrst_state", MASTER_STATE, 0);
        chk("mrst_mc", MASTER_CONTROL, 0);
        chk("mrst_srst", SLAVE_RESET, 0);
        chk("mrst_flags", {BUSY, DONE, ERROR}, 0);
        chk("mrst_err", ERR_CODE, 0);
        RESET = 1'b0;
        tick();

        push(1, 2, 3, 4, 5);
        pulse_start();
        wait_state(3'd1, 10);
        wait_state(3'd5, 100);
        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
